// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg: shared types and constants for the serial pattern generator.
//   seq_state_e  - FSM state encoding (IDLE, SEND, GAP, DONE)
//   DEF_PAT      - default 4-bit pattern used by the 1101-style detectors
//   bit_cnt_w()  - width of a counter able to hold PAT_W-1
package seq_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } seq_state_e;

    // A PAT_W-bit frame needs a bit index from PAT_W-1 down to 0.
    function automatic int bit_cnt_w(input int pat_w);
        return (pat_w < 2) ? 1 : $clog2(pat_w);
    endfunction

    localparam int DEF_PAT_W = 4;
    localparam int DEF_CNT_W = 8;
    localparam int DEF_GAP_W = 4;
    localparam int DEF_BIT_W = bit_cnt_w(DEF_PAT_W);

    localparam logic [DEF_PAT_W-1:0] DEF_PAT = 4'b1101;

endpackage

// File: rtl/seq_down_cnt.sv
// seq_down_cnt: loadable down-counter that saturates at zero.
//   clk, rst_n - clock, asynchronous active-low reset
//   clr        - force count to zero (highest priority)
//   load       - load load_val
//   dec        - decrement by one; ignored when count is already zero
//   count      - current value
//   is_zero    - count == 0
module seq_down_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         is_zero
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign is_zero = (count == '0);

endmodule

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: bit-serial pattern transmitter.
// Latches pattern/reps/gap on an accepted start, sends the pattern MSB-first
// reps times with gap zero-bits between frames, then pulses done.
//
// Handshake: start is a request sampled only in IDLE; it is accepted at the
// edge where state==IDLE and start==1, there is no ready signal, and busy
// plus the following done pulse tell the requester when a new start will be
// taken again (the cycle after done).
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   start        - transfer request (IDLE only)
//   pattern      - frame bits, MSB first
//   reps         - number of frames (0 = no bits, immediate done)
//   gap          - zero-bit cycles between frames
//   abort        - cancel a transfer in SEND/GAP, no done pulse
//   x, x_valid   - serial data and qualifier (frame and gap bits)
//   frame_start  - first bit of each frame
//   busy         - in SEND or GAP
//   done         - one-cycle completion pulse
//   dbg_state    - current FSM state
module seq_pattern_gen
    import seq_gen_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int CNT_W = DEF_CNT_W,
    parameter int GAP_W = DEF_GAP_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] reps,
    input  logic [GAP_W-1:0] gap,
    input  logic             abort,
    output logic             x,
    output logic             x_valid,
    output logic             frame_start,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);

    localparam int BIT_W = bit_cnt_w(PAT_W);

    seq_state_e       state;
    logic [PAT_W-1:0] shreg;
    logic [PAT_W-1:0] pat_q;
    logic [GAP_W-1:0] gap_len;
    logic             frame_start_q;

    logic [BIT_W-1:0] bit_cnt;
    logic             bit_zero;
    logic [CNT_W-1:0] rep_left;
    logic             rep_zero;
    logic [GAP_W-1:0] gap_cnt;
    logic             gap_zero;

    logic accept;
    logic kill;
    logic frame_end;
    logic last_frame;
    logic next_frame;

    assign accept     = (state == IDLE) && start && (reps != '0);
    assign kill       = abort && ((state == SEND) || (state == GAP));
    assign frame_end  = (state == SEND) && bit_zero && !abort;
    // rep_left is never zero in SEND; treating zero as "last" keeps the
    // counter from ever wrapping if that invariant were broken.
    assign last_frame = (rep_left == CNT_W'(1)) || rep_zero;
    assign next_frame = frame_end && !last_frame;

    seq_down_cnt #(.W(BIT_W)) u_bit_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (kill),
        .load     (accept || next_frame),
        .load_val (BIT_W'(PAT_W - 1)),
        .dec      ((state == SEND) && !bit_zero),
        .count    (bit_cnt),
        .is_zero  (bit_zero)
    );

    seq_down_cnt #(.W(CNT_W)) u_rep_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (kill),
        .load     (accept),
        .load_val (reps),
        .dec      (next_frame),
        .count    (rep_left),
        .is_zero  (rep_zero)
    );

    // gap_cnt counts the remaining gap cycles after the current one.
    seq_down_cnt #(.W(GAP_W)) u_gap_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (kill),
        .load     (next_frame && (gap_len != '0)),
        .load_val (gap_len - 1'b1),
        .dec      ((state == GAP) && !gap_zero),
        .count    (gap_cnt),
        .is_zero  (gap_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            shreg         <= '0;
            pat_q         <= '0;
            gap_len       <= '0;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (reps != '0) begin
                            shreg         <= pattern;
                            pat_q         <= pattern;
                            gap_len       <= gap;
                            frame_start_q <= 1'b1;
                            state         <= SEND;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                SEND: begin
                    if (abort) begin
                        state   <= IDLE;
                        shreg   <= '0;
                        pat_q   <= '0;
                        gap_len <= '0;
                    end else if (bit_zero) begin
                        if (last_frame) begin
                            shreg <= '0;
                            state <= DONE;
                        end else begin
                            shreg <= pat_q;
                            if (gap_len == '0) begin
                                frame_start_q <= 1'b1;
                            end else begin
                                state <= GAP;
                            end
                        end
                    end else begin
                        shreg <= {shreg[PAT_W-2:0], 1'b0};
                    end
                end
                GAP: begin
                    if (abort) begin
                        state   <= IDLE;
                        shreg   <= '0;
                        pat_q   <= '0;
                        gap_len <= '0;
                    end else if (gap_zero) begin
                        frame_start_q <= 1'b1;
                        state         <= SEND;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode registered state only; no input reaches an output
    // combinationally.
    assign x           = (state == SEND) && shreg[PAT_W-1];
    assign x_valid     = (state == SEND) || (state == GAP);
    assign busy        = (state == SEND) || (state == GAP);
    assign done        = (state == DONE);
    assign frame_start = frame_start_q;
    assign dbg_state   = state;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb_seq_pattern_gen: directed bench for seq_pattern_gen with a stream model
// and per-cycle output comparison.
module tb_seq_pattern_gen;
    import seq_gen_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] pattern;
    logic [7:0] reps;
    logic [3:0] gap;
    logic       abort;
    logic       x;
    logic       x_valid;
    logic       frame_start;
    logic       busy;
    logic       done;
    logic [1:0] dbg_state;

    seq_pattern_gen #(.PAT_W(4), .CNT_W(8), .GAP_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .pattern     (pattern),
        .reps        (reps),
        .gap         (gap),
        .abort       (abort),
        .x           (x),
        .x_valid     (x_valid),
        .frame_start (frame_start),
        .busy        (busy),
        .done        (done),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    // Entry layout: {x, x_valid, frame_start, busy, done}
    logic [4:0] exp_q[$];
    int         vectors = 0;
    int         misc = 0;
    bit         chk_en = 1'b0;

    int          acc_cyc;
    int          done_cyc;
    logic [31:0] xs;
    int          xcnt;
    logic [3:0]  det;
    int          det_hits;

    logic [4:0] got_v;
    logic [4:0] exp_v;

    // Stream model: what the serial line must carry for one transfer.
    function automatic void model_push(input logic [3:0] p, input int r, input int g);
        for (int f = 0; f < r; f++) begin
            for (int b = 3; b >= 0; b--) begin
                exp_q.push_back({p[b], 1'b1, (b == 3), 1'b1, 1'b0});
            end
            if (f < r - 1) begin
                for (int k = 0; k < g; k++) exp_q.push_back(5'b01010);
            end
        end
        exp_q.push_back(5'b00001);
    endfunction

    // Compare process: every cycle out of reset, outputs must equal the
    // model's next entry, or the idle pattern when nothing is pending.
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            got_v = {x, x_valid, frame_start, busy, done};
            exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 5'b00000;
            vectors++;
            if (got_v !== exp_v) begin
                misc++;
                $display("FAIL stream cyc=%0d got=%b exp=%b (x,xv,fs,busy,done)", cyc, got_v, exp_v);
            end
            if (x_valid) begin
                xs = {xs[30:0], x};
                xcnt++;
                det = {det[2:0], x};
                if (det == 4'b1101) det_hits++;
            end
            if (done) done_cyc = cyc;
        end
    end

    // ---------------- driver / check tasks ----------------
    task automatic chk(input string name, input int act, input int expv);
        vectors++;
        if (act !== expv) begin
            misc++;
            $display("FAIL %s got=%0d exp=%0d", name, act, expv);
        end
    endtask

    // Called at posedge+1; start is accepted at the next edge.
    task automatic send(input logic [3:0] p, input int r, input int g, input bit with_abort);
        pattern = p;
        reps    = 8'(r);
        gap     = 4'(g);
        start   = 1'b1;
        abort   = with_abort;
        @(posedge clk);
        #1;
        start   = 1'b0;
        abort   = 1'b0;
        pattern = 4'($urandom_range(0, 15));
        reps    = 8'($urandom_range(0, 255));
        gap     = 4'($urandom_range(0, 15));
        acc_cyc  = cyc;
        done_cyc = -1;
        xs       = '0;
        xcnt     = 0;
        det      = '0;
        det_hits = 0;
        model_push(p, r, g);
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (exp_q.size() != 0) begin
            vectors++;
            misc++;
            $display("FAIL drain_timeout got=%0d pending exp=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    function automatic int latency();
        return (done_cyc < 0) ? -1 : done_cyc - acc_cyc + 1;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        pattern = '0; reps = '0; gap = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", int'({x, x_valid, frame_start, busy, done}), 0);
        chk("reset_state", int'(dbg_state), 0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 1101 x1, no gap
        send(4'b1101, 1, 0, 1'b0);
        chk("t1_model_len", exp_q.size(), 5);
        drain(50);
        chk("t1_bits", int'(xs[3:0]), 4'b1101);
        chk("t1_nbits", xcnt, 4);
        chk("t1_done_lat", latency(), 5);

        // 1101 x2, back-to-back frames, next start right after done
        send(4'b1101, 2, 0, 1'b0);
        drain(50);
        chk("t2_bits", int'(xs[7:0]), 8'b11011101);
        chk("t2_det_hits", det_hits, 2);
        chk("t2_done_lat", latency(), 9);

        // 1101 x2 with 3-cycle gap
        send(4'b1101, 2, 3, 1'b0);
        chk("t3_model_len", exp_q.size(), 12);
        drain(50);
        chk("t3_bits", int'(xs[10:0]), 11'b11010001101);
        chk("t3_nbits", xcnt, 11);
        chk("t3_done_lat", latency(), 12);

        // reps=0, then a start pulsed in the DONE cycle must be ignored
        send(4'b1101, 0, 0, 1'b0);
        pattern = 4'b1111; reps = 8'd1; gap = 4'd0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("t4_done_lat", latency(), 1);
        chk("t4_nbits", xcnt, 0);

        // abort in IDLE alone does nothing
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("idle_abort_state", int'(dbg_state), 0);

        // reps=3 gap=2, abort in cycle T+6, new start in T+7
        send(4'b1101, 3, 2, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        exp_q.delete();
        chk("t5_abort_outs", int'({x_valid, busy, done}), 0);
        chk("t5_nbits_before_abort", xcnt, 6);
        chk("t5_no_done", done_cyc, -1);
        send(4'b0110, 1, 0, 1'b0);
        drain(50);
        chk("t5_restart_lat", latency(), 5);
        chk("t5_restart_bits", int'(xs[3:0]), 4'b0110);

        // start and abort together in IDLE: start wins
        send(4'b1001, 1, 0, 1'b1);
        drain(50);
        chk("t6_bits", int'(xs[3:0]), 4'b1001);
        chk("t6_done_lat", latency(), 5);

        // asynchronous reset while in GAP
        send(4'b1101, 3, 4, 1'b0);
        repeat (5) @(posedge clk);
        #3;
        chk("t7_in_gap", int'(dbg_state), 2);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("t7_reset_outs", int'({x, x_valid, frame_start, busy, done}), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        send(4'b1011, 1, 0, 1'b0);
        drain(50);
        chk("t7_bits", int'(xs[3:0]), 4'b1011);
        chk("t7_done_lat", latency(), 5);

        // default pattern, several frames with a 1-cycle gap
        send(DEF_PAT, 4, 1, 1'b0);
        drain(100);
        chk("t8_done_lat", latency(), 20);
        chk("t8_det_hits", det_hits, 4);

        // maximum reps and gap must not wrap
        send(4'b1010, 255, 15, 1'b0);
        drain(6000);
        chk("t9_nbits", xcnt, 255 * 4 + 254 * 15);
        chk("t9_done_lat", latency(), 255 * 4 + 254 * 15 + 1);

        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
